// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide scheduler: op codes, HI/LO
// write-select codes and the controller FSM states.
package muldiv_hilo_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] HILO_SEL_BOTH = 2'b00;
    localparam logic [1:0] HILO_SEL_HI   = 2'b11;
    localparam logic [1:0] HILO_SEL_LO   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_div_radix2.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, W cycles per
// divide. done_o marks the cycle whose edge retires the final step.
module div_radix2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         abort_i,
    output logic         done_o,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o
);

    localparam int CW = $clog2(W) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        b_d    = b_q;
        rem_sh = {rem_q, quot_q[W-1]};
        diff   = rem_sh - {1'b0, b_q};
        done_o = busy_q && (cnt_q == CW'(W - 1));
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quot_d = a_i;
            rem_d  = '0;
            b_d    = b_i;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            // Dividend bits shift out of the quotient register as quotient bits shift in.
            if (!diff[W]) begin
                rem_d  = diff[W-1:0];
                quot_d = {quot_q[W-2:0], 1'b1};
            end else begin
                rem_d  = rem_sh[W-1:0];
                quot_d = {quot_q[W-2:0], 1'b0};
            end
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            b_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            b_q    <= b_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Execute-stage HI/LO scheduler: multi-cycle MULT/DIV with pipeline stall and one
// HI/LO write, plus single-cycle MTHI/MTLO. Optional macro: DIV_EARLY_OUT_EN.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int W       = 32
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start_i,
    input  logic [2:0]     op_i,
    input  logic [W-1:0]   src_a_i,
    input  logic [W-1:0]   src_b_i,
    input  logic           flush_i,
    output logic           stall_o,
    output logic           busy_o,
    output logic           hilo_we_o,
    output logic [1:0]     hilo_sel_o,
    output logic [2*W-1:0] hilo_wdata_o
);

    md_state_e      state_q, state_d;
    logic [W-1:0]   a_q, b_q;
    logic           sgn_q, is_div_q, q_neg_q, r_neg_q;
    logic [1:0]     mul_cnt_q;
    logic [2*W-1:0] mul_pipe_q [MUL_LAT];
`ifdef DIV_EARLY_OUT_EN
    logic           early_q, bz_q;
`endif

    logic           is_mul_op, is_div_op, is_sgn_op, a_neg, b_neg, accept;
    logic [W-1:0]   abs_a, abs_b;
    logic [2*W-1:0] a_ext, b_ext, product;
    logic           div_done, early_exit;
    logic [W-1:0]   div_quot, div_rem, q_fix, r_fix;
    logic [2*W-1:0] div_result;
    logic           stall_c, we_c;
    logic [1:0]     sel_c;
    logic [2*W-1:0] wdata_c;

    assign is_mul_op = (op_i == MD_MULT) || (op_i == MD_MULTU);
    assign is_div_op = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign is_sgn_op = op_is_signed(op_i);
    assign a_neg     = is_sgn_op && src_a_i[W-1];
    assign b_neg     = is_sgn_op && src_b_i[W-1];
    assign abs_a     = a_neg ? -src_a_i : src_a_i;
    assign abs_b     = b_neg ? -src_b_i : src_b_i;
    assign accept    = (state_q == IDLE) && start_i && !flush_i && (is_mul_op || is_div_op);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            is_div_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            mul_cnt_q <= '0;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= 1'b0;
            bz_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q       <= src_a_i;
                b_q       <= src_b_i;
                sgn_q     <= is_sgn_op;
                is_div_q  <= is_div_op;
                // A zero divisor yields an all-ones quotient, which must never be negated.
                q_neg_q   <= (a_neg ^ b_neg) && (src_b_i != '0);
                r_neg_q   <= a_neg;
                mul_cnt_q <= '0;
`ifdef DIV_EARLY_OUT_EN
                early_q   <= (abs_b == '0) || (abs_a < abs_b);
                bz_q      <= (abs_b == '0);
`endif
            end else if (state_q == MUL) begin
                mul_cnt_q <= mul_cnt_q + 1'b1;
            end
        end
    end

    assign a_ext   = {{W{sgn_q & a_q[W-1]}}, a_q};
    assign b_ext   = {{W{sgn_q & b_q[W-1]}}, b_q};
    assign product = a_ext * b_ext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= '0;
        end else begin
            mul_pipe_q[0] <= product;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
        end
    end

    div_radix2 #(.W(W)) u_div (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (accept && is_div_op),
        .a_i     (abs_a),
        .b_i     (abs_b),
        .abort_i (flush_i || early_exit),
        .done_o  (div_done),
        .quot_o  (div_quot),
        .rem_o   (div_rem)
    );

    always_comb begin
        q_fix      = q_neg_q ? -div_quot : div_quot;
        r_fix      = r_neg_q ? -div_rem : div_rem;
        div_result = {r_fix, q_fix};
`ifdef DIV_EARLY_OUT_EN
        if (early_q) div_result = {a_q, {W{bz_q}}};
`endif
    end

    always_comb begin
        state_d    = state_q;
        we_c       = 1'b0;
        sel_c      = HILO_SEL_BOTH;
        wdata_c    = '0;
        early_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    if (is_mul_op) begin
                        state_d = MUL;
                    end else if (is_div_op) begin
                        state_d = DIV;
                    end else if (op_i == MD_MTHI) begin
                        we_c    = 1'b1;
                        sel_c   = HILO_SEL_HI;
                        wdata_c = {src_a_i, {W{1'b0}}};
                    end else if (op_i == MD_MTLO) begin
                        we_c    = 1'b1;
                        sel_c   = HILO_SEL_LO;
                        wdata_c = {{W{1'b0}}, src_a_i};
                    end
                end
            end
            MUL: begin
                if (mul_cnt_q == 2'(MUL_LAT - 1)) state_d = DONE;
            end
            DIV: begin
`ifdef DIV_EARLY_OUT_EN
                if (early_q) begin
                    early_exit = 1'b1;
                    state_d    = DONE;
                end else
`endif
                if (div_done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                we_c    = 1'b1;
                wdata_c = is_div_q ? div_result : mul_pipe_q[MUL_LAT-1];
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including the DONE writeback.
        if (flush_i) begin
            state_d = IDLE;
            we_c    = 1'b0;
        end
    end

    assign stall_c = start_i && (is_mul_op || is_div_op) && (state_q != DONE) && !flush_i;

    assign stall_o      = resetn && stall_c;
    assign busy_o       = resetn && (state_q != IDLE);
    assign hilo_we_o    = resetn && we_c;
    assign hilo_sel_o   = resetn ? sel_c : 2'b00;
    assign hilo_wdata_o = resetn ? wdata_c : '0;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: directed spec cases plus randomized MULT/DIV traffic
// checked against an arithmetic reference model.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;

    logic          clk;
    logic          resetn;
    logic          start_i;
    logic [2:0]    op_i;
    logic [W-1:0]  src_a_i;
    logic [W-1:0]  src_b_i;
    logic          flush_i;
    logic          stall_o;
    logic          busy_o;
    logic          hilo_we_o;
    logic [1:0]    hilo_sel_o;
    logic [63:0]   hilo_wdata_o;

    int tests_run = 0;
    int fail_cnt  = 0;

    muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT), .W(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start_i      (start_i),
        .op_i         (op_i),
        .src_a_i      (src_a_i),
        .src_b_i      (src_b_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .hilo_we_o    (hilo_we_o),
        .hilo_sel_o   (hilo_sel_o),
        .hilo_wdata_o (hilo_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Architectural result {HI,LO} for an arithmetic HI/LO op.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        logic [63:0] ua, ub;
        sa = int'(a);
        sb = int'(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  return 64'(longint'(sa) * longint'(sb));
            MD_MULTU: return ua * ub;
            MD_DIVU:  begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (op == MD_MULT || op == MD_MULTU) return MUL_LAT + 1;
        if (op == MD_DIV) begin
            ma = longint'(int'(a));
            mb = longint'(int'(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'(a);
            mb = longint'(b);
        end
`ifdef DIV_EARLY_OUT_EN
        if (mb == 0 || ma < mb) return 2;
`endif
        return 33;
    endfunction

    // Presents one arithmetic op from a point just after a rising edge and observes it
    // until the stall drops; returns just after the edge that retires it, start_i still high.
    task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output int writes, output bit last_we,
                            output logic [1:0] sel, output logic [63:0] data);
        start_i = 1'b1;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        stalls  = 0;
        writes  = 0;
        last_we = 1'b0;
        sel     = 2'bxx;
        data    = 'x;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (hilo_we_o) begin
                writes++;
                sel  = hilo_sel_o;
                data = hilo_wdata_o;
            end
            if (!stall_o) begin
                last_we = hilo_we_o;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        start_i = 1'b0;
        op_i    = '0;
        src_a_i = '0;
        src_b_i = '0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (stall_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        tests_run++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        tests_run++; if (hilo_we_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_we got=%b exp=0", hilo_we_o); end
        tests_run++; if (hilo_sel_o !== 2'b00) begin fail_cnt++; $display("FAIL reset_sel got=%b exp=00", hilo_sel_o); end
        tests_run++; if (hilo_wdata_o !== 64'd0) begin fail_cnt++; $display("FAIL reset_wdata got=%h exp=0", hilo_wdata_o); end
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        tests_run++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL post_reset_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_mult_directed();
        int stalls, writes; bit last_we; logic [1:0] sel; logic [63:0] data;
        @(posedge clk); #1;
        drive_md(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, stalls, writes, last_we, sel, data);
        start_i = 1'b0;
        tests_run++; if (stalls !== 3) begin fail_cnt++; $display("FAIL mult_stalls got=%0d exp=3", stalls); end
        tests_run++; if (writes !== 1 || last_we !== 1'b1) begin fail_cnt++; $display("FAIL mult_writes got=%0d/%b exp=1/1", writes, last_we); end
        tests_run++; if (sel !== 2'b00) begin fail_cnt++; $display("FAIL mult_sel got=%b exp=00", sel); end
        tests_run++; if (data !== 64'hFFFF_FFFF_FFFF_FFFA) begin fail_cnt++; $display("FAIL mult_data got=%h exp=fffffffffffffffa", data); end
    endtask

    task automatic test_div_directed();
        logic [2:0]  t_op  [6] = '{MD_DIVU, MD_DIV, MD_DIV, MD_DIVU, MD_DIV, MD_DIVU};
        logic [31:0] t_a   [6] = '{32'd100, 32'hFFFF_FFF9, 32'h1234, 32'h1234, 32'h8000_0000, 32'd5};
        logic [31:0] t_b   [6] = '{32'd7, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd9};
        logic [63:0] t_exp [6] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                   {32'h1234, 32'hFFFF_FFFF}, {32'h1234, 32'hFFFF_FFFF},
                                   {32'd0, 32'h8000_0000}, {32'd5, 32'd0}};
        int stalls, writes, exp_st; bit last_we; logic [1:0] sel; logic [63:0] data;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            drive_md(t_op[i], t_a[i], t_b[i], stalls, writes, last_we, sel, data);
            exp_st = ref_stalls(t_op[i], t_a[i], t_b[i]);
            tests_run++; if (stalls !== exp_st) begin fail_cnt++; $display("FAIL div_stalls case=%0d got=%0d exp=%0d", i, stalls, exp_st); end
            tests_run++; if (writes !== 1 || last_we !== 1'b1 || sel !== 2'b00) begin fail_cnt++; $display("FAIL div_write case=%0d got=%0d/%b sel=%b exp=1/1 sel=00", i, writes, last_we, sel); end
            tests_run++; if (data !== t_exp[i]) begin fail_cnt++; $display("FAIL div_data case=%0d got=%h exp=%h", i, data, t_exp[i]); end
        end
        start_i = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b; logic [63:0] exp_d;
        int stalls, writes, exp_st; bit last_we; logic [1:0] sel; logic [63:0] data;
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(0, 12)); end
                2: b = 32'd0;
                default: begin a = 32'($urandom_range(0, 1000)); b = b | 32'h0001_0000; end
            endcase
            if ($urandom_range(0, 3) == 0) a = -a;
            exp_d  = ref_result(op, a, b);
            exp_st = ref_stalls(op, a, b);
            drive_md(op, a, b, stalls, writes, last_we, sel, data);
            tests_run++; if (stalls !== exp_st) begin fail_cnt++; $display("FAIL rand_stalls op=%0d a=%h b=%h got=%0d exp=%0d", op, a, b, stalls, exp_st); end
            tests_run++; if (writes !== 1 || last_we !== 1'b1) begin fail_cnt++; $display("FAIL rand_writes op=%0d got=%0d/%b exp=1/1", op, writes, last_we); end
            tests_run++; if (sel !== 2'b00) begin fail_cnt++; $display("FAIL rand_sel op=%0d got=%b exp=00", op, sel); end
            tests_run++; if (data !== exp_d) begin fail_cnt++; $display("FAIL rand_data op=%0d a=%h b=%h got=%h exp=%h", op, a, b, data, exp_d); end
        end
        start_i = 1'b0;
    endtask

    task automatic test_flush();
        int stalls, writes, stray; bit last_we; logic [1:0] sel; logic [63:0] data;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_DIVU; src_a_i = 32'hFFFF_0000; src_b_i = 32'h0000_0123;
        repeat (11) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        tests_run++; if (hilo_we_o !== 1'b0 || stall_o !== 1'b0) begin fail_cnt++; $display("FAIL flush_div_cycle we=%b stall=%b exp=0/0", hilo_we_o, stall_o); end
        @(posedge clk);
        #1 flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        tests_run++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL flush_div_busy got=%b exp=0", busy_o); end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hilo_we_o) stray++;
        end
        tests_run++; if (stray !== 0) begin fail_cnt++; $display("FAIL flush_div_stray_write got=%0d exp=0", stray); end
        @(posedge clk); #1;
        drive_md(MD_MULTU, 32'd3, 32'd5, stalls, writes, last_we, sel, data);
        start_i = 1'b0;
        tests_run++; if (writes !== 1 || stalls !== MUL_LAT + 1) begin fail_cnt++; $display("FAIL post_flush_mul writes=%0d stalls=%0d exp=1/%0d", writes, stalls, MUL_LAT + 1); end
        tests_run++; if (data !== 64'd15) begin fail_cnt++; $display("FAIL post_flush_mul_data got=%h exp=000000000000000f", data); end
        // Flush landing on the writeback cycle of a multiply must suppress the write.
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_MULT; src_a_i = 32'd7; src_b_i = 32'd9;
        repeat (MUL_LAT + 1) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        tests_run++; if (hilo_we_o !== 1'b0) begin fail_cnt++; $display("FAIL flush_done_we got=%b exp=0", hilo_we_o); end
        @(posedge clk);
        #1 flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        tests_run++; if (busy_o !== 1'b0 || hilo_we_o !== 1'b0) begin fail_cnt++; $display("FAIL flush_done_after busy=%b we=%b exp=0/0", busy_o, hilo_we_o); end
    endtask

    task automatic test_mthi_mtlo();
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_MTHI; src_a_i = 32'h0000_AAAA; src_b_i = $urandom;
        @(negedge clk);
        tests_run++; if ({stall_o, hilo_we_o, hilo_sel_o} !== 4'b0111) begin fail_cnt++; $display("FAIL mthi_ctrl stall/we/sel got=%b/%b/%b exp=0/1/11", stall_o, hilo_we_o, hilo_sel_o); end
        tests_run++; if (hilo_wdata_o[63:32] !== 32'h0000_AAAA) begin fail_cnt++; $display("FAIL mthi_data got=%h exp=0000aaaa", hilo_wdata_o[63:32]); end
        @(posedge clk); #1;
        op_i = MD_MTLO; src_a_i = 32'h0000_5555;
        @(negedge clk);
        tests_run++; if ({stall_o, hilo_we_o, hilo_sel_o} !== 4'b0110) begin fail_cnt++; $display("FAIL mtlo_ctrl stall/we/sel got=%b/%b/%b exp=0/1/10", stall_o, hilo_we_o, hilo_sel_o); end
        tests_run++; if (hilo_wdata_o[31:0] !== 32'h0000_5555) begin fail_cnt++; $display("FAIL mtlo_data got=%h exp=00005555", hilo_wdata_o[31:0]); end
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        tests_run++; if (hilo_we_o !== 1'b0 || busy_o !== 1'b0) begin fail_cnt++; $display("FAIL mt_after we=%b busy=%b exp=0/0", hilo_we_o, busy_o); end
    endtask

    task automatic test_illegal();
        logic [2:0] bad_ops [2] = '{3'd6, 3'd7};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start_i = 1'b1; op_i = bad_ops[i]; src_a_i = $urandom; src_b_i = $urandom;
            @(negedge clk);
            tests_run++; if (stall_o !== 1'b0 || hilo_we_o !== 1'b0) begin fail_cnt++; $display("FAIL illegal_op op=%0d stall=%b we=%b exp=0/0", bad_ops[i], stall_o, hilo_we_o); end
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            tests_run++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL illegal_busy op=%0d got=%b exp=0", bad_ops[i], busy_o); end
        end
    endtask

    task automatic test_back_to_back();
        int stalls, writes; bit last_we; logic [1:0] sel; logic [63:0] data;
        @(posedge clk); #1;
        drive_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, writes, last_we, sel, data);
        tests_run++; if (data !== 64'hFFFF_FFFE_0000_0001 || writes !== 1) begin fail_cnt++; $display("FAIL b2b_mul got=%h writes=%0d exp=fffffffe00000001/1", data, writes); end
        drive_md(MD_DIVU, 32'd1000, 32'd33, stalls, writes, last_we, sel, data);
        tests_run++; if (data !== {32'd10, 32'd30} || stalls !== 33) begin fail_cnt++; $display("FAIL b2b_div got=%h stalls=%0d exp=0000000a0000001e/33", data, stalls); end
        op_i = MD_MTHI; src_a_i = 32'hCAFE_F00D;
        @(negedge clk);
        tests_run++; if (hilo_we_o !== 1'b1 || hilo_sel_o !== 2'b11 || hilo_wdata_o[63:32] !== 32'hCAFE_F00D) begin fail_cnt++; $display("FAIL b2b_mthi we=%b sel=%b hi=%h exp=1/11/cafef00d", hilo_we_o, hilo_sel_o, hilo_wdata_o[63:32]); end
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        int stalls, writes; bit last_we; logic [1:0] sel; logic [63:0] data;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_DIVU; src_a_i = 32'h0010_0000; src_b_i = 32'd3;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        tests_run++; if ({stall_o, busy_o, hilo_we_o, hilo_sel_o, hilo_wdata_o} !== 69'd0) begin fail_cnt++; $display("FAIL reset_mid_div stall=%b busy=%b we=%b sel=%b data=%h exp=all 0", stall_o, busy_o, hilo_we_o, hilo_sel_o, hilo_wdata_o); end
        @(posedge clk); #1;
        start_i = 1'b0;
        resetn  = 1'b1;
        @(posedge clk); #1;
        drive_md(MD_DIVU, 32'd9, 32'd3, stalls, writes, last_we, sel, data);
        start_i = 1'b0;
        tests_run++; if (data !== {32'd0, 32'd3} || writes !== 1) begin fail_cnt++; $display("FAIL post_reset_div got=%h writes=%0d exp=0000000000000003/1", data, writes); end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_mthi_mtlo();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
